// File: rtl/uart_pkg.sv
// Shared types and constants for the framed UART transmitter.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} tx_state_t;

  localparam logic [3:0] MIN_DATA_BITS = 4'd5;
  localparam logic       IDLE_LVL      = 1'b1;

  // Out-of-range frame lengths fall back to the widest supported frame.
  function automatic logic [3:0] clamp_bits(input logic [3:0] b, input logic [3:0] max_b);
    return (b < MIN_DATA_BITS || b > max_b) ? max_b : b;
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy counter and synchronous clear; head word is shown on rdata_o.
module uart_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Clear takes priority over both ports in the same cycle.
  assign do_push = push_i && !full_o && !clr_i;
  assign do_pop  = pop_i && !empty_o && !clr_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop) count_d = count_q + CW'(1);
      if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: FIFO-fed, per-frame latched config (length, parity, stop bits, baud period).
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int BAUD_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BAUD_W-1:0]             BAUD_PERIOD,
  input  logic [3:0]                    data_bits,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          two_stop,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic                          TX
);
  tx_state_t          state_q;
  logic [BAUD_W-1:0]  baud_q, period_q;
  logic [3:0]         bit_q, nbits_q, nbits_d;
  logic [DATA_W-1:0]  shreg_q, head;
  logic               par_en_q, two_stop_q, par_q, par_d;
  logic               tx_q, busy_q, done_q;
  logic               full, empty, pop, bit_end;

  uart_sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush),
    .push_i  (in_valid),
    .wdata_i (in_data),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  assign in_ready = !full;
  assign pop      = (state_q == IDLE) && !empty && !flush;
  assign bit_end  = (baud_q == period_q);
  assign TX       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

  // Parity over the active data bits only; shreg_q holds the popped word during LOAD.
  always_comb begin
    nbits_d = clamp_bits(data_bits, 4'(DATA_W));
    par_d   = parity_odd;
    for (int i = 0; i < DATA_W; i++)
      if (4'(i) < nbits_d) par_d = par_d ^ shreg_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      period_q   <= '0;
      bit_q      <= '0;
      nbits_q    <= '0;
      shreg_q    <= '0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= IDLE_LVL;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= IDLE_LVL;
          if (pop) begin
            shreg_q <= head;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          nbits_q    <= nbits_d;
          par_en_q   <= parity_en;
          two_stop_q <= two_stop;
          period_q   <= BAUD_PERIOD;
          par_q      <= par_d;
          baud_q     <= '0;
          bit_q      <= '0;
          busy_q     <= 1'b1;
          tx_q       <= 1'b0;
          state_q    <= START;
        end
        START: begin
          if (bit_end) begin
            baud_q  <= '0;
            tx_q    <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
            state_q <= DATA;
          end else baud_q <= baud_q + BAUD_W'(1);
        end
        DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == nbits_q - 4'd1) begin
              bit_q   <= '0;
              tx_q    <= par_en_q ? par_q : IDLE_LVL;
              state_q <= par_en_q ? PARITY : STOP;
            end else begin
              bit_q   <= bit_q + 4'd1;
              tx_q    <= shreg_q[0];
              shreg_q <= shreg_q >> 1;
            end
          end else baud_q <= baud_q + BAUD_W'(1);
        end
        PARITY: begin
          if (bit_end) begin
            baud_q  <= '0;
            tx_q    <= IDLE_LVL;
            state_q <= STOP;
          end else baud_q <= baud_q + BAUD_W'(1);
        end
        STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            if (two_stop_q && bit_q == 4'd0) bit_q <= 4'd1;
            else begin
              bit_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end else baud_q <= baud_q + BAUD_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
